// File: rtl/spi_reg_pkg.sv
// Shared types and address map for the SPI register bank and its arbiter.
// Words below FPGA_BASE belong to the Pi, words from FPGA_BASE up belong to local writers.
package spi_reg_pkg;

    typedef enum logic {ARB, OWNED} statetype;

    localparam int PI_BASE   = 0;
    localparam int FPGA_BASE = 8;
    localparam int N_WORDS   = 16;
    localparam int ADDR_W    = 4;

    localparam int ST_SPARE      = 0;
    localparam int ST_SPI_WR_ERR = 1;
    localparam int ST_LOCK_TO    = 2;

    function automatic logic is_fpga_word(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_W'(FPGA_BASE);
    endfunction

endpackage

// File: rtl/spi_reg_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping; one-hot result.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// 16-word SPI register bank: SPI write port, round-robin local writers with locked bursts, shadowed reads.
// Writes land at the edge ending the request cycle, reads return one cycle later; SPI writes stall local grants.
module spi_reg_arbiter
    import spi_reg_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*4-1:0]        req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      req_err,
    input  logic                      spi_wr_en,
    input  logic [3:0]                spi_wr_addr,
    input  logic [DATA_W-1:0]         spi_wr_data,
    input  logic                      spi_rd_req,
    input  logic [3:0]                spi_rd_addr,
    output logic [DATA_W-1:0]         spi_rd_data,
    output logic                      spi_rd_valid,
    output logic [N_WORDS*DATA_W-1:0] bank_q,
    output logic [N_WORDS-1:0]        upd_strobe,
    output logic [2:0]                status
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam int N_SHD = N_WORDS - FPGA_BASE;

    statetype          state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt, owner, owner_nxt, gidx;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic              lock_to_set;

    logic [DATA_W-1:0] bank   [N_WORDS];
    logic [DATA_W-1:0] shadow [N_SHD];

    logic [N_REQ-1:0]  cand, gnt_raw, grant;
    logic [3:0]        g_addr;
    logic [DATA_W-1:0] g_data;
    logic              g_lock, g_hit, owner_vld;

    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    // While a burst is owned, only the owner competes.
    always_comb begin
        cand = req_valid;
        if (state == OWNED) begin
            cand        = '0;
            cand[owner] = req_valid[owner];
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (cand),
        .ptr (ptr),
        .gnt (gnt_raw)
    );

    // The bank has one write port and SPI wins it; reset also kills the handshake.
    assign grant     = (reset_n && !spi_wr_en) ? gnt_raw : '0;
    assign req_ready = grant;
    assign g_hit     = |grant;
    assign owner_vld = req_valid[owner];

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) gidx = PTR_W'(i);
        end
    end

    assign g_addr  = req_addr[int'(gidx)*4 +: 4];
    assign g_data  = req_data[int'(gidx)*DATA_W +: DATA_W];
    assign g_lock  = req_lock[gidx];
    assign req_err = g_hit && !is_fpga_word(g_addr);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = spi_wr_addr;
        wr_data = spi_wr_data;
        if (spi_wr_en) begin
            wr_en = !is_fpga_word(spi_wr_addr);
        end else if (g_hit && is_fpga_word(g_addr)) begin
            wr_en   = 1'b1;
            wr_addr = g_addr;
            wr_data = g_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        lock_cnt_nxt = lock_cnt;
        lock_to_set  = 1'b0;
        if (g_hit) begin
            ptr_nxt = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
        end
        case (state)
            ARB: begin
                if (g_hit && g_lock) begin
                    state_nxt    = OWNED;
                    owner_nxt    = gidx;
                    lock_cnt_nxt = '0;
                end
            end
            OWNED: begin
                // A withheld owner grant freezes the burst for that cycle.
                if (!(spi_wr_en && owner_vld)) begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                    if (g_hit && !g_lock) begin
                        state_nxt = ARB;
                    end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                        state_nxt   = ARB;
                        lock_to_set = 1'b1;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB;
            owner    <= '0;
            ptr      <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_WORDS; k++) bank[k] <= '0;
            for (int k = 0; k < N_SHD; k++) shadow[k] <= '0;
            upd_strobe   <= '0;
            status       <= '0;
            spi_rd_data  <= '0;
            spi_rd_valid <= 1'b0;
        end else begin
            if (wr_en) bank[wr_addr] <= wr_data;
            upd_strobe <= '0;
            if (spi_wr_en && !is_fpga_word(spi_wr_addr)) upd_strobe[spi_wr_addr] <= 1'b1;
            if (spi_wr_en && is_fpga_word(spi_wr_addr)) status[ST_SPI_WR_ERR] <= 1'b1;
            if (lock_to_set) status[ST_LOCK_TO] <= 1'b1;
            status[ST_SPARE] <= 1'b0;
            spi_rd_valid <= spi_rd_req;
            if (spi_rd_req) begin
                spi_rd_data <= is_fpga_word(spi_rd_addr) ? shadow[spi_rd_addr[2:0]] : bank[spi_rd_addr];
            end
            // Shadow tracks the post-edge bank whenever no burst is open after this edge.
            if (state_nxt == ARB) begin
                for (int k = 0; k < N_SHD; k++) begin
                    shadow[k] <= (wr_en && wr_addr == 4'(FPGA_BASE + k)) ? wr_data : bank[FPGA_BASE + k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_WORDS; k++) bank_q[k*DATA_W +: DATA_W] = bank[k];
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Bench for spi_reg_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_spi_reg_arbiter;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 8;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_REQ-1:0]        req_valid, req_lock, req_ready;
    logic [N_REQ*4-1:0]      req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    req_err, spi_wr_en, spi_rd_req, spi_rd_valid;
    logic [3:0]              spi_wr_addr, spi_rd_addr;
    logic [DATA_W-1:0]       spi_wr_data, spi_rd_data;
    logic [16*DATA_W-1:0]    bank_q;
    logic [15:0]             upd_strobe;
    logic [2:0]              status;

    spi_reg_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .req_err(req_err),
        .spi_wr_en(spi_wr_en), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
        .spi_rd_req(spi_rd_req), .spi_rd_addr(spi_rd_addr),
        .spi_rd_data(spi_rd_data), .spi_rd_valid(spi_rd_valid),
        .bank_q(bank_q), .upd_strobe(upd_strobe), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        lock;
    } wreq_t;

    wreq_t wq [N_REQ][$];

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model of the register file and ownership.
    logic [31:0] m_bank   [16];
    logic [31:0] m_shadow [16];
    logic [31:0] m_rd_data;
    logic [15:0] m_upd;
    bit          m_rd_valid, m_lock_to, m_wr_err, m_owned;
    int          m_ptr, m_owner, m_owned_cycles;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_bank[k]   = '0;
            m_shadow[k] = '0;
        end
        m_rd_data = '0; m_upd = '0; m_rd_valid = 0; m_lock_to = 0; m_wr_err = 0;
        m_owned = 0; m_ptr = 0; m_owner = 0; m_owned_cycles = 0;
    endtask

    function automatic int model_grant();
        if (!reset_n || spi_wr_en) return -1;
        if (m_owned) return req_valid[m_owner] ? m_owner : -1;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[(m_ptr + i) % N_REQ]) return (m_ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_step(input int g);
        int          wa;
        logic [31:0] wd;
        logic [3:0]  ga;
        wa = -1; wd = '0; ga = '0;
        if (g >= 0) ga = req_addr[g*4 +: 4];
        if (spi_wr_en) begin
            if (spi_wr_addr < 8) begin
                wa = int'(spi_wr_addr); wd = spi_wr_data;
            end else begin
                m_wr_err = 1;
            end
        end else if (g >= 0 && ga >= 8) begin
            wa = int'(ga); wd = req_data[g*32 +: 32];
        end
        m_rd_valid = spi_rd_req;
        if (spi_rd_req) m_rd_data = (spi_rd_addr < 8) ? m_bank[spi_rd_addr] : m_shadow[spi_rd_addr];
        m_upd = (spi_wr_en && spi_wr_addr < 8) ? (16'd1 << spi_wr_addr) : 16'd0;
        if (wa >= 0) m_bank[wa] = wd;
        if (!m_owned) begin
            if (g >= 0) begin
                m_ptr = (g + 1) % N_REQ;
                if (req_lock[g]) begin
                    m_owned = 1; m_owner = g; m_owned_cycles = 0;
                end
            end
        end else if (!(spi_wr_en && req_valid[m_owner])) begin
            if (g >= 0 && !req_lock[g]) begin
                m_owned = 0;
            end else begin
                m_owned_cycles++;
                if (m_owned_cycles == LOCK_MAX) begin
                    m_owned = 0; m_lock_to = 1;
                end
            end
        end
        if (!m_owned) for (int k = 8; k < 16; k++) m_shadow[k] = m_bank[k];
        if (g >= 0 && wq[g].size() > 0) void'(wq[g].pop_front());
    endtask

    always @(negedge clk) begin : compare
        int           g;
        logic [3:0]   exp_rdy;
        logic [511:0] exp_bank;
        if (!reset_n) model_reset();
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        for (int k = 0; k < 16; k++) exp_bank[k*32 +: 32] = m_bank[k];
        check("bank_q", bank_q, exp_bank);
        check("status", status, {m_lock_to, m_wr_err, 1'b0});
        check("upd_strobe", upd_strobe, m_upd);
        check("rd_valid", spi_rd_valid, m_rd_valid);
        check("rd_data", spi_rd_data, m_rd_data);
        check("req_ready", req_ready, exp_rdy);
        check("req_err", req_err, (g >= 0) && (req_addr[((g < 0) ? 0 : g)*4 +: 4] < 8));
        if (reset_n) model_step(g);
    end

    task automatic drive_writers();
        for (int i = 0; i < N_REQ; i++) begin
            if (wq[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_addr[i*4 +: 4]   = wq[i][0].addr;
                req_data[i*32 +: 32] = wq[i][0].data;
                req_lock[i]          = wq[i][0].lock;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_writers();
    endtask

    task automatic push(input int w, input logic [3:0] a, input logic [31:0] d, input logic l);
        wq[w].push_back('{addr: a, data: d, lock: l});
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N_REQ; i++) n += wq[i].size();
        return n;
    endfunction

    task automatic drain(input int limit);
        int n = 0;
        while (n < limit && pending() != 0) begin
            tick();
            n++;
        end
        check("drain", 32'(pending()), 0);
    endtask

    task automatic spi_write(input logic [3:0] a, input logic [31:0] d);
        spi_wr_en = 1'b1; spi_wr_addr = a; spi_wr_data = d;
        tick();
        spi_wr_en = 1'b0;
    endtask

    task automatic push_burst(input int w);
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            push(w, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15)),
                 $urandom, (k < n - 1) || ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_exp [8];
        rr_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0000, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
        reset_n = 1'b0;
        req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;
        spi_wr_en = 1'b0; spi_wr_addr = '0; spi_wr_data = '0;
        spi_rd_req = 1'b0; spi_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bank", bank_q, 0);
        check("reset_status", status, 0);
        check("reset_rd_valid", spi_rd_valid, 0);
        reset_n = 1'b1;

        // SPI writes: Pi word lands, FPGA word is refused and flagged.
        spi_write(4'd2, 32'h12345678);
        check("spi_wr_word2", bank_q[2*32 +: 32], 32'h12345678);
        check("spi_wr_strobe", upd_strobe, 16'h0004);
        tick();
        check("spi_wr_strobe_off", upd_strobe, 16'h0000);
        spi_write(4'd9, 32'hCAFEF00D);
        check("spi_wr_fpga_drop", bank_q[9*32 +: 32], 32'h0);
        check("spi_wr_err", status, 3'b010);

        // Round-robin between writers 0 and 2 with an SPI write stealing cycle 3.
        for (int k = 0; k < 4; k++) begin
            push(0, 4'd8, 32'h100 + k, 1'b0);
            push(2, 4'd10, 32'h200 + k, 1'b0);
        end
        drive_writers();
        for (int c = 0; c < 8; c++) begin
            spi_wr_en = (c == 3); spi_wr_addr = 4'd5; spi_wr_data = 32'h55;
            @(negedge clk);
            check($sformatf("rr_grant_c%0d", c), req_ready, rr_exp[c]);
            tick();
        end
        spi_wr_en = 1'b0;
        drain(20);

        // Local write to a Pi word: handshake completes with an error, bank untouched.
        push(1, 4'd3, 32'hDEAD, 1'b0);
        drive_writers();
        @(negedge clk);
        check("local_pi_ready", req_ready, 4'b0010);
        check("local_pi_err", req_err, 1'b1);
        tick();
        check("local_pi_word3", bank_q[3*32 +: 32], 32'h0);

        // Locked burst by writer 1 with writer 3 waiting; reads see pre-burst shadow.
        push(0, 4'd9, 32'h11, 1'b0);
        push(0, 4'd10, 32'h22, 1'b0);
        drive_writers();
        drain(20);
        push(1, 4'd9, 32'hA, 1'b1);
        push(1, 4'd10, 32'hB, 1'b1);
        push(1, 4'd11, 32'hC, 1'b0);
        push(3, 4'd12, 32'h33, 1'b0);
        drive_writers();
        @(negedge clk);
        check("burst_c0", req_ready, 4'b0010);
        tick();
        spi_rd_req = 1'b1; spi_rd_addr = 4'd10;
        @(negedge clk);
        check("burst_c1", req_ready, 4'b0010);
        tick();
        spi_rd_req = 1'b0;
        check("burst_rd_valid", spi_rd_valid, 1'b1);
        check("burst_rd_old", spi_rd_data, 32'h22);
        @(negedge clk);
        check("burst_c2", req_ready, 4'b0010);
        tick();
        spi_rd_req = 1'b1; spi_rd_addr = 4'd10;
        @(negedge clk);
        check("burst_w3_after", req_ready, 4'b1000);
        tick();
        spi_rd_req = 1'b0;
        check("burst_rd_new", spi_rd_data, 32'hB);
        check("burst_words", bank_q[9*32 +: 96], {32'hC, 32'hB, 32'hA});

        // Stranded lock: writer 0 holds lock without valid until the timeout.
        push(0, 4'd13, 32'h77, 1'b1);
        drive_writers();
        @(negedge clk);
        check("to_grant0", req_ready, 4'b0001);
        tick();
        push(2, 4'd14, 32'h88, 1'b0);
        drive_writers();
        for (int k = 0; k < LOCK_MAX; k++) begin
            @(negedge clk);
            check($sformatf("to_stall_%0d", k), req_ready, 4'b0000);
            tick();
        end
        check("to_status", status, 3'b110);
        @(negedge clk);
        check("to_grant2", req_ready, 4'b0100);
        tick();

        // Reset in the middle of traffic.
        push(1, 4'd8, 32'h1, 1'b0);
        drive_writers();
        @(negedge clk);
        check("pre_rst_grant", req_ready, 4'b0010);
        tick();
        push(1, 4'd9, 32'h2, 1'b0);
        push(3, 4'd10, 32'h3, 1'b0);
        drive_writers();
        reset_n = 1'b0;
        #1;
        check("rst_bank", bank_q, 0);
        check("rst_rd_data", spi_rd_data, 0);
        check("rst_ready", req_ready, 0);
        check("rst_status", status, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ptr0", req_ready, 4'b0010);
        tick();
        drain(20);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            spi_wr_en   = ($urandom_range(0, 9) == 0);
            spi_wr_addr = 4'($urandom_range(0, 15));
            spi_wr_data = $urandom;
            spi_rd_req  = ($urandom_range(0, 3) == 0);
            spi_rd_addr = 4'($urandom_range(0, 15));
            for (int w = 0; w < N_REQ; w++) begin
                if (wq[w].size() == 0 && $urandom_range(0, 4) == 0) push_burst(w);
            end
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
            drive_writers();
            tick();
        end
        spi_wr_en = 1'b0;
        spi_rd_req = 1'b0;
        drain(300);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
